// File: rtl/blob_centroid_extractor.sv
// blob_centroid_extractor
// Once a frame has been labelled, this block walks the per-label feature table
// (weight, sum_x, sum_y). For each label that is large enough it divides both
// weighted sums by the weight and streams out one centroid record per label.
// Labels are visited in ascending order. Label 0 is background and is never read.
module blob_centroid_extractor #(
    parameter int WORD_SIZE   = 8,
    parameter int ACC_WIDTH   = 48,
    parameter int COORD_WIDTH = 32,
    parameter int MIN_AREA    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [WORD_SIZE-1:0]   num_labels,
    output logic [WORD_SIZE-1:0]   rd_addr,
    input  logic [3*ACC_WIDTH-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_SIZE-1:0]   out_id,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_y,
    output logic [ACC_WIDTH-1:0]   out_area
);

    localparam int EXT_WIDTH = ACC_WIDTH + COORD_WIDTH;
    localparam int CNT_WIDTH = $clog2(COORD_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_STEP  = CNT_WIDTH'(COORD_WIDTH - 1);
    localparam logic [ACC_WIDTH-1:0] MIN_WEIGHT = ACC_WIDTH'(MIN_AREA);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DIV,
        EMIT,
        FINISH
    } state_t;

    state_t state, next_state;

    logic [WORD_SIZE-1:0]   label_cnt;
    logic [WORD_SIZE-1:0]   last_label;
    logic                   advance;
    logic                   is_last_label;

    logic [ACC_WIDTH-1:0]   rd_weight;
    logic [ACC_WIDTH-1:0]   rd_sum_x;
    logic [ACC_WIDTH-1:0]   rd_sum_y;
    logic                   below_min;

    logic [EXT_WIDTH-1:0]   ext_x;
    logic [EXT_WIDTH-1:0]   ext_y;
    logic [EXT_WIDTH-1:0]   ext_w;
    logic                   ovf_x;
    logic                   ovf_y;

    logic [ACC_WIDTH-1:0]   weight_r;
    logic [ACC_WIDTH:0]     rem_x;
    logic [ACC_WIDTH:0]     rem_y;
    logic [COORD_WIDTH-1:0] shf_x;
    logic [COORD_WIDTH-1:0] shf_y;
    logic                   sat_x;
    logic                   sat_y;
    logic [CNT_WIDTH-1:0]   div_cnt;
    logic                   last_div;

    logic [ACC_WIDTH+1:0]   divisor_ext;
    logic [ACC_WIDTH+1:0]   trial_x;
    logic [ACC_WIDTH+1:0]   trial_y;
    logic                   fit_x;
    logic                   fit_y;
    logic [ACC_WIDTH:0]     next_rem_x;
    logic [ACC_WIDTH:0]     next_rem_y;
    logic [COORD_WIDTH-1:0] next_q_x;
    logic [COORD_WIDTH-1:0] next_q_y;

    // Split the feature record into its three fields.
    assign rd_weight = rd_data[ACC_WIDTH-1:0];
    assign rd_sum_x  = rd_data[2*ACC_WIDTH-1:ACC_WIDTH];
    assign rd_sum_y  = rd_data[3*ACC_WIDTH-1:2*ACC_WIDTH];
    assign below_min = (rd_weight < MIN_WEIGHT);

    // The quotient needs more than COORD_WIDTH bits exactly when sum >= weight << COORD_WIDTH.
    // In that case it saturates, so the divider only has to produce the low COORD_WIDTH bits.
    assign ext_x = {{COORD_WIDTH{1'b0}}, rd_sum_x};
    assign ext_y = {{COORD_WIDTH{1'b0}}, rd_sum_y};
    assign ext_w = {rd_weight, {COORD_WIDTH{1'b0}}};
    assign ovf_x = (ext_x >= ext_w);
    assign ovf_y = (ext_y >= ext_w);

    // One restoring step: shift the next dividend bit into the partial remainder.
    // Subtract the divisor whenever the result does not go negative.
    assign divisor_ext = {2'b00, weight_r};
    assign trial_x     = {rem_x, shf_x[COORD_WIDTH-1]};
    assign trial_y     = {rem_y, shf_y[COORD_WIDTH-1]};
    assign fit_x       = (trial_x >= divisor_ext);
    assign fit_y       = (trial_y >= divisor_ext);
    assign next_rem_x  = fit_x ? (ACC_WIDTH+1)'(trial_x - divisor_ext) : (ACC_WIDTH+1)'(trial_x);
    assign next_rem_y  = fit_y ? (ACC_WIDTH+1)'(trial_y - divisor_ext) : (ACC_WIDTH+1)'(trial_y);
    assign next_q_x    = {shf_x[COORD_WIDTH-2:0], fit_x};
    assign next_q_y    = {shf_y[COORD_WIDTH-2:0], fit_y};
    assign last_div    = (div_cnt == LAST_STEP);

    assign is_last_label = (label_cnt == last_label);
    assign rd_addr       = label_cnt;

    // State register. A low reset_n abandons any scan that is in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, together with the status and handshake outputs for the current state.
    always_comb begin
        next_state = state;
        advance    = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (num_labels > WORD_SIZE'(1)) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                next_state = CHECK;
            end
            CHECK: begin
                if (!below_min) begin
                    next_state = DIV;
                end else if (is_last_label) begin
                    next_state = FINISH;
                end else begin
                    next_state = ISSUE;
                    advance    = 1'b1;
                end
            end
            DIV: begin
                if (last_div) begin
                    next_state = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (is_last_label) begin
                        next_state = FINISH;
                    end else begin
                        next_state = ISSUE;
                        advance    = 1'b1;
                    end
                end
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The label counter doubles as the read address. last_label marks where the scan ends.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            label_cnt  <= '0;
            last_label <= '0;
        end else if (state == IDLE && next_state == ISSUE) begin
            label_cnt  <= WORD_SIZE'(1);
            last_label <= num_labels - WORD_SIZE'(1);
        end else if (advance) begin
            label_cnt  <= label_cnt + WORD_SIZE'(1);
        end
    end

    // Two restoring dividers share one divisor and produce one quotient bit per DIV cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            weight_r <= '0;
            rem_x    <= '0;
            rem_y    <= '0;
            shf_x    <= '0;
            shf_y    <= '0;
            sat_x    <= 1'b0;
            sat_y    <= 1'b0;
            div_cnt  <= '0;
        end else if (state == CHECK && !below_min) begin
            weight_r <= rd_weight;
            rem_x    <= (ACC_WIDTH+1)'(ext_x >> COORD_WIDTH);
            rem_y    <= (ACC_WIDTH+1)'(ext_y >> COORD_WIDTH);
            shf_x    <= COORD_WIDTH'(ext_x);
            shf_y    <= COORD_WIDTH'(ext_y);
            sat_x    <= ovf_x;
            sat_y    <= ovf_y;
            div_cnt  <= '0;
        end else if (state == DIV) begin
            rem_x    <= next_rem_x;
            rem_y    <= next_rem_y;
            shf_x    <= next_q_x;
            shf_y    <= next_q_y;
            div_cnt  <= div_cnt + CNT_WIDTH'(1);
        end
    end

    // Capture the finished record so that it stays stable for the whole EMIT handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_id   <= '0;
            out_x    <= '0;
            out_y    <= '0;
            out_area <= '0;
        end else if (state == DIV && last_div) begin
            out_id   <= label_cnt;
            out_area <= weight_r;
            out_x    <= sat_x ? '1 : next_q_x;
            out_y    <= sat_y ? '1 : next_q_y;
        end
    end

endmodule
